controlador_hierarquia: RTL and testbench
=========================================

// Module: controlador_hierarquia
// PURPOSE
//  Sequencing controller for the two-level memory hierarchy: a 2-line, fully
//  associative, write-back / write-allocate L1 cache in front of the RAM.
//  Owns the tag/valid/dirty/LRU state and the L1 data. Accepts one CPU request
//  at a time, resolves hit/miss, and drives RAM write-back and fill transactions
//  over a req/ack handshake. Keeps hit/miss statistics for the board display.
// PARAMETERS
//  ADDR_W  8  CPU/RAM address width (full address is the tag)
//  DATA_W  8  word width
// PORTS
//  clock      in   1       single clock, all state on posedge
//  reset      in   1       synchronous, active-low
//  cpu_req    in   1       request strobe, sampled only while cpu_ready=1
//  cpu_write  in   1       1=write, 0=read
//  cpu_addr   in   ADDR_W  request address
//  cpu_wdata  in   DATA_W  write data
//  cpu_ready  out  1       controller idle, can accept a request
//  cpu_done   out  1       1-cycle pulse: request complete
//  cpu_rdata  out  DATA_W  read data, valid with cpu_done, held until next done
//  cpu_hit    out  1       1=request hit in L1, valid with cpu_done, held
//  mem_req    out  1       RAM transaction active, held until mem_ack
//  mem_write  out  1       1=write-back, 0=fill
//  mem_addr   out  ADDR_W  RAM address
//  mem_wdata  out  DATA_W  write-back data
//  mem_ack    in   1       1-cycle pulse from RAM: transaction complete
//  mem_rdata  in   DATA_W  fill data, valid with mem_ack
//  hit_cnt    out  8       hits completed, wraps 255->0
//  miss_cnt   out  8       misses completed, wraps 255->0
// BEHAVIOUR
//  Reset (reset=0 at posedge): state=IDLE; both lines valid=0, dirty=0,
//   tag=0, data=0; lru=0; cpu_done, cpu_hit, cpu_rdata, mem_* outputs,
//   hit_cnt, miss_cnt=0. cpu_ready=1 in first cycle after reset released.
//   Reset mid-operation aborts: no cpu_done, dirty data discarded, mem_req=0.
//  lru = index of least recently used line; any access to line i sets lru=~i.
//  States: IDLE, LOOKUP, WB, FILL, DONE. cpu_ready=1 only in IDLE.
//  IDLE: cpu_req=1 at edge T -> latch addr/write/wdata -> LOOKUP at T+1.
//   cpu_req in any other state is ignored (not queued).
//  LOOKUP (1 cycle): hit = line valid and tag==addr (at most one line matches).
//   Read hit: rdata<=data. Write hit: data<=wdata, dirty<=1. Both -> DONE.
//   Miss: victim = lowest-index invalid line, else line[lru].
//   victim valid&dirty -> WB, else -> FILL.
//  WB: mem_req=1, mem_write=1, mem_addr=victim tag, mem_wdata=victim data;
//   on mem_ack: victim dirty<=0 -> FILL.
//  FILL: mem_req=1, mem_write=0, mem_addr=latched addr; on mem_ack:
//   victim tag<=addr, valid<=1; read: data<=mem_rdata, dirty<=0,
//   rdata<=mem_rdata; write: data<=wdata, dirty<=1 (fill data discarded) -> DONE.
//  WB->FILL: mem_req stays 1; each ack pulse completes exactly one transaction.
//  mem_ack while mem_req=0 ignored. mem_* outputs stable while waiting on ack.
//  DONE (1 cycle): cpu_done=1, cpu_hit valid; hit_cnt or miss_cnt +1 -> IDLE.
//  Latency: hit -> cpu_done at T+2; miss -> T+2 + one cycle per RAM wait cycle.
//  Writes complete to L1 only; RAM is updated solely by WB on eviction.
// TESTING
//  1 reset; read 0x64, RAM acks 0x05 next cycle -> mem_req fill @0x64,
//    cpu_done rdata=0x05 hit=0, miss_cnt=1; re-read 0x64 -> done at T+2, hit=1,
//    no mem_req.
//  2 write 0x65=0xAA (miss) -> fill @0x65 then line1 data 0xAA dirty; read 0x65
//    -> rdata=0xAA hit=1, no RAM traffic.
//  3 continue: read 0x64 (hit, lru=1); read 0x66 -> WB addr=0x65 wdata=0xAA,
//    then fill 0x66; read 0x64 still hits.
//  4 fill with mem_ack delayed 5 cycles -> mem_req/mem_addr held 5 cycles,
//    cpu_done exactly 1 cycle after ack; cpu_req pulses meanwhile ignored.
//  5 reset=0 during FILL -> next cycle mem_req=0, no cpu_done, counters 0;
//    read 0x64 afterwards -> miss (cache invalid).
//  6 256 read hits -> hit_cnt wraps to 0; miss_cnt unchanged.

Source files
------------

// File: rtl/controlador_hierarquia.sv
// controlador_hierarquia
//   Sequencing controller for a two-level memory hierarchy. It holds a 2-line,
//   fully associative, write-back / write-allocate L1 cache (tag, valid, dirty,
//   LRU and data) in front of a RAM. It accepts one CPU request at a time,
//   resolves hit/miss, and runs RAM write-back and fill transactions over a
//   req/ack handshake. It also counts hits and misses for the board display.
//
// Ports
//   clock, reset           : single clock; synchronous active-low reset
//   cpu_req/write/addr/wdata : CPU request, sampled only while cpu_ready=1
//   cpu_ready              : controller idle
//   cpu_done               : one-cycle completion pulse
//   cpu_rdata, cpu_hit     : read data and hit flag, held until next completion
//   mem_req/write/addr/wdata : RAM transaction, held until mem_ack
//   mem_ack, mem_rdata     : RAM completion pulse and fill data
//   hit_cnt, miss_cnt      : 8-bit wrapping statistics
module controlador_hierarquia #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_write,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ready,
   output logic              cpu_done,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_hit,
   output logic              mem_req,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [7:0]        hit_cnt,
   output logic [7:0]        miss_cnt
);

   typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WB, S_FILL, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              write_q, write_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [1:0]        valid_q, valid_d;
   logic [1:0]        dirty_q, dirty_d;
   logic [ADDR_W-1:0] tag_q [2];
   logic [ADDR_W-1:0] tag_d [2];
   logic [DATA_W-1:0] data_q [2];
   logic [DATA_W-1:0] data_d [2];
   logic              lru_q, lru_d;
   logic              victim_q, victim_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              hit_q, hit_d;
   logic [7:0]        hit_cnt_q, hit_cnt_d;
   logic [7:0]        miss_cnt_q, miss_cnt_d;

   logic match0, match1, match_idx, miss_victim;

   // At most one line can match, since a fill never installs a tag that is
   // already resident (a resident tag would have hit).
   assign match0      = valid_q[0] && (tag_q[0] == addr_q);
   assign match1      = valid_q[1] && (tag_q[1] == addr_q);
   assign match_idx   = match1;
   // Prefer an empty line; only evict the LRU line when both are valid.
   assign miss_victim = !valid_q[0] ? 1'b0 : (!valid_q[1] ? 1'b1 : lru_q);

   assign cpu_rdata = rdata_q;
   assign cpu_hit   = hit_q;
   assign hit_cnt   = hit_cnt_q;
   assign miss_cnt  = miss_cnt_q;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      write_d    = write_q;
      wdata_d    = wdata_q;
      valid_d    = valid_q;
      dirty_d    = dirty_q;
      tag_d[0]   = tag_q[0];
      tag_d[1]   = tag_q[1];
      data_d[0]  = data_q[0];
      data_d[1]  = data_q[1];
      lru_d      = lru_q;
      victim_d   = victim_q;
      rdata_d    = rdata_q;
      hit_d      = hit_q;
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      cpu_ready  = 1'b0;
      cpu_done   = 1'b0;
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;

      case (state_q)
         S_IDLE: begin
            cpu_ready = 1'b1;
            if (cpu_req) begin
               addr_d  = cpu_addr;
               write_d = cpu_write;
               wdata_d = cpu_wdata;
               state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            if (match0 || match1) begin
               hit_d = 1'b1;
               lru_d = ~match_idx;
               if (write_q) begin
                  data_d[match_idx]  = wdata_q;
                  dirty_d[match_idx] = 1'b1;
               end else begin
                  rdata_d = data_q[match_idx];
               end
               state_d = S_DONE;
            end else begin
               hit_d    = 1'b0;
               victim_d = miss_victim;
               if (valid_q[miss_victim] && dirty_q[miss_victim]) begin
                  state_d = S_WB;
               end else begin
                  state_d = S_FILL;
               end
            end
         end
         S_WB: begin
            mem_req   = 1'b1;
            mem_write = 1'b1;
            mem_addr  = tag_q[victim_q];
            mem_wdata = data_q[victim_q];
            if (mem_ack) begin
               dirty_d[victim_q] = 1'b0;
               state_d           = S_FILL;
            end
         end
         S_FILL: begin
            mem_req  = 1'b1;
            mem_addr = addr_q;
            if (mem_ack) begin
               tag_d[victim_q]   = addr_q;
               valid_d[victim_q] = 1'b1;
               lru_d             = ~victim_q;
               if (write_q) begin
                  // Write-allocate: the CPU word overrides the fetched word.
                  data_d[victim_q]  = wdata_q;
                  dirty_d[victim_q] = 1'b1;
               end else begin
                  data_d[victim_q]  = mem_rdata;
                  dirty_d[victim_q] = 1'b0;
                  rdata_d           = mem_rdata;
               end
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            cpu_done = 1'b1;
            if (hit_q) hit_cnt_d = hit_cnt_q + 8'd1;
            else       miss_cnt_d = miss_cnt_q + 8'd1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         write_q    <= 1'b0;
         wdata_q    <= '0;
         valid_q    <= '0;
         dirty_q    <= '0;
         tag_q[0]   <= '0;
         tag_q[1]   <= '0;
         data_q[0]  <= '0;
         data_q[1]  <= '0;
         lru_q      <= 1'b0;
         victim_q   <= 1'b0;
         rdata_q    <= '0;
         hit_q      <= 1'b0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         write_q    <= write_d;
         wdata_q    <= wdata_d;
         valid_q    <= valid_d;
         dirty_q    <= dirty_d;
         tag_q[0]   <= tag_d[0];
         tag_q[1]   <= tag_d[1];
         data_q[0]  <= data_d[0];
         data_q[1]  <= data_d[1];
         lru_q      <= lru_d;
         victim_q   <= victim_d;
         rdata_q    <= rdata_d;
         hit_q      <= hit_d;
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

endmodule

// File: tb/tb_controlador_hierarquia.sv
// Testbench for controlador_hierarquia: directed CPU requests, a RAM model that
// checks each expected RAM transaction, and a monitor that checks every
// completion against a queue of hand-computed expected responses.
module tb_controlador_hierarquia;

   logic       clock = 1'b0;
   logic       reset;
   logic       cpu_req, cpu_write;
   logic [7:0] cpu_addr, cpu_wdata;
   logic       cpu_ready, cpu_done, cpu_hit;
   logic [7:0] cpu_rdata;
   logic       mem_req, mem_write, mem_ack;
   logic [7:0] mem_addr, mem_wdata, mem_rdata;
   logic [7:0] hit_cnt, miss_cnt;

   always #5 clock = ~clock;

   controlador_hierarquia #(.ADDR_W(8), .DATA_W(8)) dut (
      .clock(clock), .reset(reset),
      .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
      .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   typedef struct {
      bit         wr;
      bit         hit;
      logic [7:0] rd;
      int         issue;
   } cpu_exp_t;

   typedef struct {
      bit         wr;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] ret;
   } mem_exp_t;

   cpu_exp_t exp_q[$];
   mem_exp_t mem_q[$];
   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int last_ack_cyc = -100;
   int ack_delay = 0;

   always @(posedge clock) cyc <= cyc + 1;

   // Completion monitor.
   cpu_exp_t mon_e;
   always @(negedge clock) begin
      if (reset && cpu_done) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_done: cpu_done=1 with no request outstanding (cycle %0d)", cyc);
         end else begin
            mon_e = exp_q.pop_front();
            if (cpu_hit !== mon_e.hit || (!mon_e.wr && cpu_rdata !== mon_e.rd)) begin
               n_err++;
               $display("FAIL done_resp: got hit=%0b rdata=%02h, expected hit=%0b rdata=%02h (wr=%0b)",
                        cpu_hit, cpu_rdata, mon_e.hit, mon_e.rd, mon_e.wr);
            end
            n_vec++;
            if (mon_e.hit && cyc != mon_e.issue + 2) begin
               n_err++;
               $display("FAIL hit_latency: done at cycle %0d, expected %0d", cyc, mon_e.issue + 2);
            end else if (!mon_e.hit && cyc != last_ack_cyc + 1) begin
               n_err++;
               $display("FAIL miss_latency: done at cycle %0d, expected %0d (ack+1)", cyc, last_ack_cyc + 1);
            end
         end
      end
   end

   // RAM model: checks each transaction against the expected list, holds the
   // ack back for ack_delay cycles while checking the request stays stable.
   mem_exp_t ram_e;
   logic [7:0] ram_a0;
   logic       ram_w0;
   bit         ram_held;
   initial begin
      mem_ack   = 1'b0;
      mem_rdata = 8'h00;
      forever begin
         @(negedge clock);
         mem_ack = 1'b0;
         if (reset && mem_req) begin
            n_vec++;
            ram_e = '{wr: 1'b0, addr: 8'h00, wdata: 8'h00, ret: 8'h00};
            if (mem_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_mem: write=%0b addr=%02h, expected no RAM traffic", mem_write, mem_addr);
            end else begin
               ram_e = mem_q.pop_front();
               if (mem_write !== ram_e.wr || mem_addr !== ram_e.addr ||
                   (ram_e.wr && mem_wdata !== ram_e.wdata)) begin
                  n_err++;
                  $display("FAIL mem_txn: got write=%0b addr=%02h wdata=%02h, expected write=%0b addr=%02h wdata=%02h",
                           mem_write, mem_addr, mem_wdata, ram_e.wr, ram_e.addr, ram_e.wdata);
               end
            end
            ram_a0   = mem_addr;
            ram_w0   = mem_write;
            ram_held = 1'b1;
            for (int i = 0; i < ack_delay; i++) begin
               @(negedge clock);
               if (!mem_req) break;
               if (mem_addr !== ram_a0 || mem_write !== ram_w0) ram_held = 1'b0;
            end
            if (mem_req) begin
               n_vec++;
               if (!ram_held) begin
                  n_err++;
                  $display("FAIL mem_hold: request changed while waiting, now addr=%02h, expected %02h", mem_addr, ram_a0);
               end
               mem_rdata    = ram_e.ret;
               mem_ack      = 1'b1;
               last_ack_cyc = cyc;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h, expected %02h", name, act, exp);
      end
   endtask

   task automatic mem_push(input bit wr, input logic [7:0] a, input logic [7:0] wd, input logic [7:0] ret);
      mem_exp_t m;
      m.wr = wr; m.addr = a; m.wdata = wd; m.ret = ret;
      mem_q.push_back(m);
   endtask

   task automatic issue(input bit wr, input logic [7:0] a, input logic [7:0] wd,
                        input bit eh, input logic [7:0] er);
      cpu_exp_t e;
      int n = 0;
      while (!cpu_ready && n < 20) begin
         @(negedge clock);
         n++;
      end
      e.wr = wr; e.hit = eh; e.rd = er; e.issue = cyc;
      exp_q.push_back(e);
      cpu_write = wr; cpu_addr = a; cpu_wdata = wd; cpu_req = 1'b1;
      @(negedge clock);
      cpu_req = 1'b0;
   endtask

   task automatic wait_done(input bit noise);
      int n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         @(negedge clock);
         n++;
         if (noise) begin
            cpu_req   = ~cpu_req;
            cpu_addr  = 8'h10 + 8'(n);
            cpu_write = n[1];
         end
      end
      cpu_req = 1'b0;
      if (exp_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL done_timeout: no cpu_done within 60 cycles, %0d outstanding", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic req(input bit wr, input logic [7:0] a, input logic [7:0] wd,
                      input bit eh, input logic [7:0] er);
      issue(wr, a, wd, eh, er);
      wait_done(1'b0);
      @(negedge clock);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      chk("reset_ready", {7'd0, cpu_ready}, 8'h01);
      chk("reset_done",  {7'd0, cpu_done},  8'h00);
      chk("reset_mreq",  {7'd0, mem_req},   8'h00);
      chk("reset_hit",   {7'd0, cpu_hit},   8'h00);
      chk("reset_rdata", cpu_rdata, 8'h00);
      chk("reset_hcnt",  hit_cnt,   8'h00);
      chk("reset_mcnt",  miss_cnt,  8'h00);

      // 1: cold read miss, then hit
      mem_push(1'b0, 8'h64, 8'h00, 8'h05);
      req(1'b0, 8'h64, 8'h00, 1'b0, 8'h05);
      chk("t1_mcnt", miss_cnt, 8'd1);
      req(1'b0, 8'h64, 8'h00, 1'b1, 8'h05);
      chk("t1_hcnt", hit_cnt, 8'd1);

      // 2: write-allocate miss into line 1, then read hit
      mem_push(1'b0, 8'h65, 8'h00, 8'h33);
      req(1'b1, 8'h65, 8'hAA, 1'b0, 8'h00);
      req(1'b0, 8'h65, 8'h00, 1'b1, 8'hAA);
      chk("t2_hcnt", hit_cnt, 8'd2);
      chk("t2_mcnt", miss_cnt, 8'd2);

      // 3: LRU eviction of the dirty line 0x65
      req(1'b0, 8'h64, 8'h00, 1'b1, 8'h05);
      mem_push(1'b1, 8'h65, 8'hAA, 8'h00);
      mem_push(1'b0, 8'h66, 8'h00, 8'h77);
      req(1'b0, 8'h66, 8'h00, 1'b0, 8'h77);
      req(1'b0, 8'h64, 8'h00, 1'b1, 8'h05);
      chk("t3_hcnt", hit_cnt, 8'd4);
      chk("t3_mcnt", miss_cnt, 8'd3);

      // 4: slow RAM, CPU request noise while busy
      ack_delay = 5;
      mem_push(1'b0, 8'h67, 8'h00, 8'h99);
      issue(1'b0, 8'h67, 8'h00, 1'b0, 8'h99);
      wait_done(1'b1);
      @(negedge clock);
      ack_delay = 0;
      chk("t4_mcnt", miss_cnt, 8'd4);
      chk("t4_hcnt", hit_cnt, 8'd4);

      // 5: reset in the middle of a fill
      ack_delay = 20;
      mem_push(1'b0, 8'h68, 8'h00, 8'h11);
      issue(1'b0, 8'h68, 8'h00, 1'b0, 8'h11);
      repeat (3) @(negedge clock);
      chk("t5_mreq_busy", {7'd0, mem_req}, 8'h01);
      chk("t5_maddr_busy", mem_addr, 8'h68);
      reset = 1'b0;
      exp_q.delete();
      @(negedge clock);
      reset = 1'b1;
      chk("t5_mreq_rst", {7'd0, mem_req}, 8'h00);
      chk("t5_done_rst", {7'd0, cpu_done}, 8'h00);
      chk("t5_hcnt_rst", hit_cnt, 8'h00);
      chk("t5_mcnt_rst", miss_cnt, 8'h00);
      ack_delay = 0;
      mem_q.delete();
      repeat (4) @(negedge clock);
      mem_push(1'b0, 8'h64, 8'h00, 8'h05);
      req(1'b0, 8'h64, 8'h00, 1'b0, 8'h05);
      chk("t5_mcnt", miss_cnt, 8'd1);

      // 6: 256 hits wrap the hit counter
      for (int i = 0; i < 256; i++) begin
         req(1'b0, 8'h64, 8'h00, 1'b1, 8'h05);
         if (i == 254) chk("t6_hcnt_255", hit_cnt, 8'd255);
      end
      chk("t6_hcnt_wrap", hit_cnt, 8'd0);
      chk("t6_mcnt", miss_cnt, 8'd1);
      chk("t6_mem_left", 8'(mem_q.size()), 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
